fifo_rd_stream: RTL and testbench

Read-side drain engine for the asynchronous FIFO. Runs entirely in the FIFO read clock domain. Issues read enables against the FIFO read port and absorbs the one-cycle read-data latency in a 3-entry buffer. Presents words downstream on a valid/ready stream at one word per cycle, with no combinational path from `i_ready` to `o_r_en`.

---
 rtl/fifo_rd_pkg.sv | 18 +
 rtl/fifo_rd_buf.sv | 70 +++++++
 rtl/fifo_rd_stream.sv | 71 +++++++
 tb/tb_fifo_rd_stream.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared constants and types for the FIFO read-side drain engine.
package fifo_rd_pkg;

    localparam int unsigned BufDepth = 3;
    localparam int unsigned OccW     = 2;
    localparam int unsigned CntW     = 16;

    typedef logic [OccW-1:0] occ_t;
    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t CntSat = 16'hFFFF;

    // Pointer increment modulo the buffer depth.
    function automatic occ_t ptr_inc(input occ_t ptr);
        return (ptr == occ_t'(BufDepth - 1)) ? '0 : ptr + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// 3-entry circular buffer absorbing the FIFO read-data latency.
module fifo_rd_buf
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DataW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [DataW-1:0] wdata,
    output logic [DataW-1:0] head,
    output occ_t             occ
);

    logic [DataW-1:0] mem_q [BufDepth];
    occ_t             wptr_q, wptr_d;
    occ_t             rptr_q, rptr_d;
    occ_t             occ_q, occ_d;
    logic             pop_ok;

    assign pop_ok = pop && (occ_q != '0);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        if (clear) begin
            wptr_d = '0;
            rptr_d = '0;
            occ_d  = '0;
        end else begin
            if (push) begin
                wptr_d = ptr_inc(wptr_q);
            end
            if (pop_ok) begin
                rptr_d = ptr_inc(rptr_q);
            end
            case ({push, pop_ok})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
            for (int i = 0; i < BufDepth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
            // A word landing in the flush cycle is dropped with the rest.
            if (push && !clear) begin
                mem_q[wptr_q] <= wdata;
            end
        end
    end

    assign head = mem_q[rptr_q];
    assign occ  = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side drain engine: issues reads, buffers data, drives a valid/ready stream.
// Optional delivered-word counter enabled by defining FIFO_RD_STAT_EN.
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int unsigned P_DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_empty,
    input  logic [P_DATA_W-1:0] i_data,
    output logic                o_r_en,
    input  logic                i_flush,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [P_DATA_W-1:0] o_data,
    output logic [CntW-1:0]     o_rd_cnt
);

    logic       infl_q;
    occ_t       occ;
    logic [2:0] fill;
    logic       capture;
    logic       handshake;

    // Issue depends only on registered state and FIFO flag, never on i_ready.
    assign fill      = {1'b0, occ} + {2'b00, infl_q};
    assign o_r_en    = !i_empty && !i_flush && (fill < 3'(BufDepth));
    assign capture   = infl_q;
    assign o_valid   = (occ != '0);
    assign handshake = o_valid && i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl_q <= 1'b0;
        end else begin
            infl_q <= o_r_en;
        end
    end

    fifo_rd_buf #(
        .DataW (P_DATA_W)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (capture),
        .pop   (handshake),
        .clear (i_flush),
        .wdata (i_data),
        .head  (o_data),
        .occ   (occ)
    );

`ifdef FIFO_RD_STAT_EN
    cnt_t rd_cnt_q;

    // Flush does not clear the counter; handshakes in the flush cycle still count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q <= '0;
        end else if (handshake && (rd_cnt_q != CntSat)) begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
        end
    end

    assign o_rd_cnt = rd_cnt_q;
`else
    assign o_rd_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream with a behavioural FIFO read-port model.
module tb_fifo_rd_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_empty;
    logic [7:0]  i_data;
    logic        o_r_en;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_data;
    logic [15:0] o_rd_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_rd_stream #(
        .P_DATA_W (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_empty  (i_empty),
        .i_data   (i_data),
        .o_r_en   (o_r_en),
        .i_flush  (i_flush),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_data   (o_data),
        .o_rd_cnt (o_rd_cnt)
    );

    // FIFO read-port model: one-cycle read latency, read side cleared by reset.
    logic [7:0] fmem [256];
    logic [7:0] f_wp = 8'd0;
    logic [7:0] f_rp;
    logic [7:0] f_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_rp   <= f_wp;
            f_data <= 8'h00;
        end else if (o_r_en) begin
            f_data <= fmem[f_rp];
            f_rp   <= f_rp + 8'd1;
        end
    end

    assign i_empty = !rst_n || (f_rp == f_wp);
    assign i_data  = f_data;

    // Capture into a full buffer must never happen.
    always @(negedge clk) begin
        if (rst_n && dut.infl_q && (dut.occ == 2'd3)) begin
            errors++;
            $display("FAIL overflow: capture with occ=%0d, required occ<3", dut.occ);
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] v);
        fmem[f_wp] = v;
        f_wp = f_wp + 8'd1;
    endtask

    task automatic do_reset();
        i_ready = 1'b0;
        i_flush = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef FIFO_RD_STAT_EN
        return 32'(n);
`else
        return 32'(n * 0);
`endif
    endfunction

    typedef struct {
        logic       ready;
        logic       exp_r_en;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_hs;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int pulses;
        int max_occ;
        int wait_n;
        logic found;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 8'h11, 0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 8'h11, 0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 8'h11, 0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 8'h11, 0};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 8'h22, 1};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 8'h33, 2};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 8'h44, 3};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 8'h00, 4};

        // Reset state
        rst_n   = 1'b0;
        i_ready = 1'b0;
        i_flush = 1'b0;
        #1;
        check("reset_r_en", 32'(o_r_en), 0);
        check("reset_valid", 32'(o_valid), 0);
        check("reset_data", 32'(o_data), 0);
        check("reset_cnt", 32'(o_rd_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Cycle-accurate latency/backpressure table
        @(negedge clk);
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        push_word(8'h44);
        for (int r = 0; r < 10; r++) begin
            if (r != 0) @(negedge clk);
            i_ready = vecs[r].ready;
            #1;
            check($sformatf("vec%0d_r_en", r), 32'(o_r_en), 32'(vecs[r].exp_r_en));
            check($sformatf("vec%0d_valid", r), 32'(o_valid), 32'(vecs[r].exp_valid));
            if (vecs[r].exp_valid) begin
                check($sformatf("vec%0d_data", r), 32'(o_data), 32'(vecs[r].exp_data));
            end
            check($sformatf("vec%0d_cnt", r), 32'(o_rd_cnt), exp_cnt(vecs[r].exp_hs));
        end

        // Reset mid-operation with two words buffered
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 8; i++) push_word(8'(8'h60 + i));
        repeat (3) @(negedge clk);
        #1;
        check("midrst_pre_occ", 32'(dut.occ), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(o_valid), 0);
        check("midrst_r_en", 32'(o_r_en), 0);
        check("midrst_cnt", 32'(o_rd_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_word(8'h77);
        #1;
        check("postrst_n0_valid", 32'(o_valid), 0);
        check("postrst_n0_r_en", 32'(o_r_en), 1);
        @(negedge clk);
        #1;
        check("postrst_n1_valid", 32'(o_valid), 0);
        @(negedge clk);
        i_ready = 1'b1;
        #1;
        check("postrst_n2_valid", 32'(o_valid), 1);
        check("postrst_n2_data", 32'(o_data), 32'h77);
        @(negedge clk);
        #1;
        check("postrst_n3_valid", 32'(o_valid), 0);

        // Streaming at full throughput
        do_reset();
        @(negedge clk);
        for (int i = 1; i <= 8; i++) push_word(8'(i));
        i_ready = 1'b1;
        wait_n = 0;
        found  = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            if (o_valid) found = 1'b1;
            else wait_n++;
        end
        check("stream_found", 32'(found), 1);
        check("stream_latency", 32'(wait_n), 2);
        for (int i = 0; i < 8; i++) begin
            if (i != 0) begin
                @(negedge clk);
                #1;
            end
            check($sformatf("stream%0d_valid", i), 32'(o_valid), 1);
            check($sformatf("stream%0d_data", i), 32'(o_data), 32'(i + 1));
        end
        @(negedge clk);
        #1;
        check("stream_end_valid", 32'(o_valid), 0);
        check("stream_cnt", 32'(o_rd_cnt), exp_cnt(8));

        // Backpressure: ten cycles stalled, then drain with no gaps
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 8; i++) push_word(8'(8'h81 + i));
        i_ready = 1'b0;
        pulses  = 0;
        max_occ = 0;
        for (int c = 0; c < 10; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            if (o_r_en) pulses++;
            if (int'(dut.occ) > max_occ) max_occ = int'(dut.occ);
        end
        check("bp_r_en_pulses", 32'(pulses), 3);
        check("bp_max_occ", 32'(max_occ), 3);
        @(negedge clk);
        i_ready = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) begin
                @(negedge clk);
                #1;
            end
            check($sformatf("bp%0d_valid", i), 32'(o_valid), 1);
            check($sformatf("bp%0d_data", i), 32'(o_data), 32'(8'h81 + i));
        end
        @(negedge clk);
        #1;
        check("bp_end_valid", 32'(o_valid), 0);

        // Flush with two buffered and one in flight
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 8; i++) push_word(8'(8'h40 + i));
        i_ready = 1'b0;
        repeat (3) @(negedge clk);
        i_flush = 1'b1;
        #1;
        check("flush_pre_occ", 32'(dut.occ), 2);
        check("flush_pre_infl", 32'(dut.infl_q), 1);
        check("flush_r_en", 32'(o_r_en), 0);
        @(negedge clk);
        i_flush = 1'b0;
        #1;
        check("flush_next_valid", 32'(o_valid), 0);
        i_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            if (o_valid) found = 1'b1;
        end
        check("flush_resume_found", 32'(found), 1);
        for (int i = 0; i < 5; i++) begin
            if (i != 0) begin
                @(negedge clk);
                #1;
            end
            check($sformatf("flush%0d_data", i), 32'(o_data), 32'(8'h43 + i));
            check($sformatf("flush%0d_valid", i), 32'(o_valid), 1);
        end
        @(negedge clk);
        #1;
        check("flush_end_valid", 32'(o_valid), 0);

        // Empty rises right after an issue: in-flight word still delivered
        do_reset();
        @(negedge clk);
        push_word(8'h5A);
        i_ready = 1'b1;
        #1;
        check("infl_n0_r_en", 32'(o_r_en), 1);
        @(negedge clk);
        #1;
        check("infl_n1_empty", 32'(i_empty), 1);
        check("infl_n1_r_en", 32'(o_r_en), 0);
        @(negedge clk);
        #1;
        check("infl_n2_valid", 32'(o_valid), 1);
        check("infl_n2_data", 32'(o_data), 32'h5A);
        check("infl_n2_r_en", 32'(o_r_en), 0);
        @(negedge clk);
        #1;
        check("infl_n3_valid", 32'(o_valid), 0);
        check("infl_n3_r_en", 32'(o_r_en), 0);

`ifdef FIFO_RD_STAT_EN
        // Counter saturation
        do_reset();
        @(negedge clk);
        force dut.rd_cnt_q = 16'hFFFE;
        push_word(8'hA1);
        push_word(8'hA2);
        push_word(8'hA3);
        i_ready = 1'b1;
        @(negedge clk);
        release dut.rd_cnt_q;
        repeat (6) @(negedge clk);
        #1;
        check("sat_cnt", 32'(o_rd_cnt), 32'hFFFF);
`else
        check("cnt_tied_zero", 32'(o_rd_cnt), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
